dcache_mshr_file: RTL and testbench

//  Parametrised multi-entry miss-status holding register file for the D-cache.

---
 rtl/dcache_pkg.sv | 24 ++
 rtl/dcache_mshr_ffs.sv | 25 ++
 rtl/dcache_mshr_file.sv | 229 ++++++++++++++++++++++
 tb/tb_dcache_mshr_file.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types for the D-cache miss handling path.
//    mshr_state_e : MSHR entry life cycle INVALID -> PENDING -> ISSUED -> FILL.
//    message_t    : coherence request carried on the bus (GET_S / GET_M).
//    DC_*         : default geometry used by dcache_mshr_file.
package dcache_pkg;

   localparam int DC_NUM_MSHR = 4;
   localparam int DC_TAG_W    = 10;
   localparam int DC_IDX_W    = 3;
   localparam int DC_WORD_W   = 64;

   typedef enum logic [1:0] {
      MSHR_INVALID = 2'd0,
      MSHR_PENDING = 2'd1,
      MSHR_ISSUED  = 2'd2,
      MSHR_FILL    = 2'd3
   } mshr_state_e;

   typedef enum logic {
      GET_S = 1'b0,
      GET_M = 1'b1
   } message_t;

endpackage

// File: rtl/dcache_mshr_ffs.sv
// dcache_mshr_ffs: find-first-set, lowest index wins.
//    req   in  N   request vector
//    found out 1   at least one bit of req set
//    idx   out W   index of the lowest set bit (0 when none)
module dcache_mshr_ffs #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   output logic         found,
   output logic [W-1:0] idx
);

   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (req[i] && !found) begin
            found = 1'b1;
            idx   = W'(i);
         end
      end
   end

endmodule

// File: rtl/dcache_mshr_file.sv
// dcache_mshr_file: multi-entry miss-status holding register file.
// Accepts misses from the D-cache controller, merges misses to a line that
// is already tracked, issues one tagged GET_S/GET_M bus request at a time,
// matches responses by entry id and hands finished lines to the fill port.
//
// Ports
//    clk, rst            clock, asynchronous active-high reset
//    alloc_*             miss allocation (en, st, tag, idx, data) and
//                        ack/merge result (combinational), full_o
//    bus_req_*           registered request (en, id, tag, idx, message),
//                        held until bus_req_ack_i
//    bus_rsp_*           response (vld, id, data)
//    fill_*              lowest-index completed line (vld, tag, idx, data,
//                        dty), consumed by fill_rdy_i
//    stat_*              only with DCACHE_MSHR_STATS_EN: saturating counts
//                        of new misses, merges and refused-alloc cycles
module dcache_mshr_file
   import dcache_pkg::*;
#(
   parameter int NUM_MSHR = DC_NUM_MSHR,
   parameter int TAG_W    = DC_TAG_W,
   parameter int IDX_W    = DC_IDX_W,
   parameter int WORD_W   = DC_WORD_W,
   parameter int ID_W     = $clog2(NUM_MSHR)   // derived, keep default
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alloc_en_i,
   input  logic              alloc_st_i,
   input  logic [TAG_W-1:0]  alloc_tag_i,
   input  logic [IDX_W-1:0]  alloc_idx_i,
   input  logic [WORD_W-1:0] alloc_data_i,
   output logic              alloc_ack_o,
   output logic              alloc_merge_o,
   output logic              full_o,
   output logic              bus_req_en_o,
   output logic [ID_W-1:0]   bus_req_id_o,
   output logic [TAG_W-1:0]  bus_req_tag_o,
   output logic [IDX_W-1:0]  bus_req_idx_o,
   output message_t          bus_req_message_o,
   input  logic              bus_req_ack_i,
   input  logic              bus_rsp_vld_i,
   input  logic [ID_W-1:0]   bus_rsp_id_i,
   input  logic [WORD_W-1:0] bus_rsp_data_i,
   output logic              fill_vld_o,
   output logic [TAG_W-1:0]  fill_tag_o,
   output logic [IDX_W-1:0]  fill_idx_o,
   output logic [WORD_W-1:0] fill_data_o,
   output logic              fill_dty_o,
`ifdef DCACHE_MSHR_STATS_EN
   output logic [31:0]       stat_miss_cnt_o,
   output logic [31:0]       stat_merge_cnt_o,
   output logic [31:0]       stat_full_cyc_o,
`endif
   input  logic              fill_rdy_i
);

   // Entry layout lives here because field widths follow the module parameters.
   typedef struct packed {
      mshr_state_e       state;
      logic [TAG_W-1:0]  tag;
      logic [IDX_W-1:0]  idx;
      logic              st;
      message_t          msg;
      logic [WORD_W-1:0] data;
   } mshr_entry_t;

   mshr_entry_t ent_q [NUM_MSHR];
   mshr_entry_t ent_d [NUM_MSHR];

   logic              req_vld_q;
   logic [ID_W-1:0]   req_id_q;
   logic [TAG_W-1:0]  req_tag_q;
   logic [IDX_W-1:0]  req_idx_q;
   message_t          req_msg_q;

   logic [NUM_MSHR-1:0] free_vec, pend_vec, fill_vec, match_vec;
   logic                free_any, pend_any, fill_any;
   logic [ID_W-1:0]     free_id, pend_id, fill_id;
   logic                hit, in_flight, ack, merge, req_upgrade;
   logic [ID_W-1:0]     hit_id;

   always_comb begin
      for (int unsigned i = 0; i < NUM_MSHR; i++) begin
         free_vec[i]  = (ent_q[i].state == MSHR_INVALID);
         fill_vec[i]  = (ent_q[i].state == MSHR_FILL);
         match_vec[i] = !free_vec[i] && (ent_q[i].tag == alloc_tag_i)
                        && (ent_q[i].idx == alloc_idx_i);
      end
   end

   // Pending search runs on next state so a fresh allocation can issue at once.
   always_comb begin
      for (int unsigned i = 0; i < NUM_MSHR; i++)
         pend_vec[i] = (ent_d[i].state == MSHR_PENDING);
   end

   dcache_mshr_ffs #(.N(NUM_MSHR), .W(ID_W)) u_ffs_free (
      .req(free_vec), .found(free_any), .idx(free_id));
   dcache_mshr_ffs #(.N(NUM_MSHR), .W(ID_W)) u_ffs_pend (
      .req(pend_vec), .found(pend_any), .idx(pend_id));
   dcache_mshr_ffs #(.N(NUM_MSHR), .W(ID_W)) u_ffs_fill (
      .req(fill_vec), .found(fill_any), .idx(fill_id));

   always_comb begin
      hit    = 1'b0;
      hit_id = '0;
      for (int unsigned i = 0; i < NUM_MSHR; i++) begin
         if (match_vec[i]) begin
            hit    = 1'b1;
            hit_id = ID_W'(i);
         end
      end
      in_flight   = req_vld_q && (req_id_q == hit_id);
      ack         = 1'b0;
      merge       = 1'b0;
      req_upgrade = 1'b0;

      if (alloc_en_i) begin
         if (hit) begin
            case (ent_q[hit_id].state)
               MSHR_PENDING: begin
                  // A GET_S leaving this very cycle cannot carry the store.
                  if (!(alloc_st_i && in_flight && bus_req_ack_i && req_msg_q == GET_S)) begin
                     ack         = 1'b1;
                     merge       = 1'b1;
                     req_upgrade = alloc_st_i && in_flight && !bus_req_ack_i;
                  end
               end
               MSHR_ISSUED: begin
                  if (!alloc_st_i || ent_q[hit_id].msg == GET_M) begin
                     ack   = 1'b1;
                     merge = 1'b1;
                  end
               end
               default: ;
            endcase
         end else if (free_any) begin
            ack = 1'b1;
         end
      end

      for (int unsigned i = 0; i < NUM_MSHR; i++)
         ent_d[i] = ent_q[i];
      if (req_vld_q && bus_req_ack_i)
         ent_d[req_id_q].state = MSHR_ISSUED;
      if (bus_rsp_vld_i && ent_q[bus_rsp_id_i].state == MSHR_ISSUED) begin
         ent_d[bus_rsp_id_i].state = MSHR_FILL;
         if (!ent_q[bus_rsp_id_i].st)
            ent_d[bus_rsp_id_i].data = bus_rsp_data_i;
      end
      if (fill_any && fill_rdy_i)
         ent_d[fill_id].state = MSHR_INVALID;
      if (ack && merge && alloc_st_i) begin
         ent_d[hit_id].st   = 1'b1;
         ent_d[hit_id].msg  = GET_M;
         ent_d[hit_id].data = alloc_data_i;
      end
      if (ack && !merge) begin
         ent_d[free_id] = '{state: MSHR_PENDING, tag: alloc_tag_i, idx: alloc_idx_i,
                            st: alloc_st_i, msg: (alloc_st_i ? GET_M : GET_S),
                            data: (alloc_st_i ? alloc_data_i : '0)};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_MSHR; i++)
            ent_q[i] <= '0;
         req_vld_q <= 1'b0;
         req_id_q  <= '0;
         req_tag_q <= '0;
         req_idx_q <= '0;
         req_msg_q <= GET_S;
      end else begin
         for (int unsigned i = 0; i < NUM_MSHR; i++)
            ent_q[i] <= ent_d[i];
         if (!req_vld_q || bus_req_ack_i) begin
            req_vld_q <= pend_any;
            if (pend_any) begin
               req_id_q  <= pend_id;
               req_tag_q <= ent_d[pend_id].tag;
               req_idx_q <= ent_d[pend_id].idx;
               req_msg_q <= ent_d[pend_id].msg;
            end
         end else if (req_upgrade) begin
            req_msg_q <= GET_M;
         end
      end
   end

   assign alloc_ack_o       = ack;
   assign alloc_merge_o     = merge;
   assign full_o            = !free_any;
   assign bus_req_en_o      = req_vld_q;
   assign bus_req_id_o      = req_id_q;
   assign bus_req_tag_o     = req_tag_q;
   assign bus_req_idx_o     = req_idx_q;
   assign bus_req_message_o = req_msg_q;
   assign fill_vld_o        = fill_any;
   assign fill_tag_o        = ent_q[fill_id].tag;
   assign fill_idx_o        = ent_q[fill_id].idx;
   assign fill_data_o       = ent_q[fill_id].data;
   assign fill_dty_o        = ent_q[fill_id].st;

`ifdef DCACHE_MSHR_STATS_EN
   logic [31:0] miss_cnt_q, merge_cnt_q, full_cyc_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         miss_cnt_q  <= '0;
         merge_cnt_q <= '0;
         full_cyc_q  <= '0;
      end else begin
         if (ack && !merge && miss_cnt_q != '1)
            miss_cnt_q <= miss_cnt_q + 32'd1;
         if (merge && merge_cnt_q != '1)
            merge_cnt_q <= merge_cnt_q + 32'd1;
         if (alloc_en_i && !ack && full_cyc_q != '1)
            full_cyc_q <= full_cyc_q + 32'd1;
      end
   end

   assign stat_miss_cnt_o  = miss_cnt_q;
   assign stat_merge_cnt_o = merge_cnt_q;
   assign stat_full_cyc_o  = full_cyc_q;
`endif

endmodule

// File: tb/tb_dcache_mshr_file.sv
// tb_dcache_mshr_file: directed, table-driven bench for dcache_mshr_file.
// Each vector holds one cycle of inputs plus the outputs expected during
// that cycle; vectors are driven after the falling edge and checked 1ns later.
module tb_dcache_mshr_file;
   import dcache_pkg::*;

   localparam int TAG_W  = 10;
   localparam int IDX_W  = 3;
   localparam int WORD_W = 64;
   localparam int ID_W   = 2;

   logic              clk, rst;
   logic              alloc_en_i, alloc_st_i;
   logic [TAG_W-1:0]  alloc_tag_i;
   logic [IDX_W-1:0]  alloc_idx_i;
   logic [WORD_W-1:0] alloc_data_i;
   logic              alloc_ack_o, alloc_merge_o, full_o;
   logic              bus_req_en_o;
   logic [ID_W-1:0]   bus_req_id_o;
   logic [TAG_W-1:0]  bus_req_tag_o;
   logic [IDX_W-1:0]  bus_req_idx_o;
   message_t          bus_req_message_o;
   logic              bus_req_ack_i, bus_rsp_vld_i;
   logic [ID_W-1:0]   bus_rsp_id_i;
   logic [WORD_W-1:0] bus_rsp_data_i;
   logic              fill_vld_o;
   logic [TAG_W-1:0]  fill_tag_o;
   logic [IDX_W-1:0]  fill_idx_o;
   logic [WORD_W-1:0] fill_data_o;
   logic              fill_dty_o, fill_rdy_i;
`ifdef DCACHE_MSHR_STATS_EN
   logic [31:0]       stat_miss_cnt_o, stat_merge_cnt_o, stat_full_cyc_o;
`endif

   int checks = 0;
   int errors = 0;

   dcache_mshr_file #(.NUM_MSHR(4), .TAG_W(TAG_W), .IDX_W(IDX_W), .WORD_W(WORD_W)) dut (
      .clk(clk), .rst(rst),
      .alloc_en_i(alloc_en_i), .alloc_st_i(alloc_st_i), .alloc_tag_i(alloc_tag_i),
      .alloc_idx_i(alloc_idx_i), .alloc_data_i(alloc_data_i),
      .alloc_ack_o(alloc_ack_o), .alloc_merge_o(alloc_merge_o), .full_o(full_o),
      .bus_req_en_o(bus_req_en_o), .bus_req_id_o(bus_req_id_o),
      .bus_req_tag_o(bus_req_tag_o), .bus_req_idx_o(bus_req_idx_o),
      .bus_req_message_o(bus_req_message_o), .bus_req_ack_i(bus_req_ack_i),
      .bus_rsp_vld_i(bus_rsp_vld_i), .bus_rsp_id_i(bus_rsp_id_i),
      .bus_rsp_data_i(bus_rsp_data_i),
      .fill_vld_o(fill_vld_o), .fill_tag_o(fill_tag_o), .fill_idx_o(fill_idx_o),
      .fill_data_o(fill_data_o), .fill_dty_o(fill_dty_o),
`ifdef DCACHE_MSHR_STATS_EN
      .stat_miss_cnt_o(stat_miss_cnt_o), .stat_merge_cnt_o(stat_merge_cnt_o),
      .stat_full_cyc_o(stat_full_cyc_o),
`endif
      .fill_rdy_i(fill_rdy_i));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   typedef struct {
      logic a_en, a_st; logic [TAG_W-1:0] a_tag; logic [IDX_W-1:0] a_idx; logic [WORD_W-1:0] a_data;
      logic q_ack, r_vld; logic [ID_W-1:0] r_id; logic [WORD_W-1:0] r_data; logic f_rdy;
      logic e_ack, e_merge, e_full, e_req; logic [ID_W-1:0] e_id; message_t e_msg;
      logic e_fill; logic [TAG_W-1:0] e_ftag; logic [IDX_W-1:0] e_fidx;
      logic [WORD_W-1:0] e_fdata; logic e_dty;
   } vec_t;

   // Argument groups: alloc(en,st,tag,idx,data) bus(q_ack,r_vld,r_id,r_data) f_rdy |
   //                  expect ack,merge,full | req(en,id,msg) | fill(vld,tag,idx,data,dty)
   function automatic vec_t mk(
         int unsigned en, int unsigned st, int unsigned tag, int unsigned idx, longint unsigned dat,
         int unsigned qa, int unsigned rv, int unsigned rid, longint unsigned rd, int unsigned fr,
         int unsigned ea, int unsigned em, int unsigned ef,
         int unsigned eq, int unsigned eid, message_t emsg,
         int unsigned fv, int unsigned ft, int unsigned fi, longint unsigned fd, int unsigned fy);
      vec_t v;
      v.a_en = 1'(en); v.a_st = 1'(st); v.a_tag = TAG_W'(tag); v.a_idx = IDX_W'(idx); v.a_data = dat;
      v.q_ack = 1'(qa); v.r_vld = 1'(rv); v.r_id = ID_W'(rid); v.r_data = rd; v.f_rdy = 1'(fr);
      v.e_ack = 1'(ea); v.e_merge = 1'(em); v.e_full = 1'(ef);
      v.e_req = 1'(eq); v.e_id = ID_W'(eid); v.e_msg = emsg;
      v.e_fill = 1'(fv); v.e_ftag = TAG_W'(ft); v.e_fidx = IDX_W'(fi); v.e_fdata = fd; v.e_dty = 1'(fy);
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic idle();
      alloc_en_i = 1'b0; alloc_st_i = 1'b0; alloc_tag_i = '0; alloc_idx_i = '0; alloc_data_i = '0;
      bus_req_ack_i = 1'b0; bus_rsp_vld_i = 1'b0; bus_rsp_id_i = '0; bus_rsp_data_i = '0;
      fill_rdy_i = 1'b0;
   endtask

   task automatic apply(input vec_t v, input string nm);
      @(negedge clk);
      alloc_en_i = v.a_en; alloc_st_i = v.a_st; alloc_tag_i = v.a_tag;
      alloc_idx_i = v.a_idx; alloc_data_i = v.a_data;
      bus_req_ack_i = v.q_ack; bus_rsp_vld_i = v.r_vld; bus_rsp_id_i = v.r_id;
      bus_rsp_data_i = v.r_data; fill_rdy_i = v.f_rdy;
      #1;
      chk({nm, ".ack"},   64'(alloc_ack_o),   64'(v.e_ack));
      chk({nm, ".merge"}, 64'(alloc_merge_o), 64'(v.e_merge));
      chk({nm, ".full"},  64'(full_o),        64'(v.e_full));
      chk({nm, ".req_en"}, 64'(bus_req_en_o), 64'(v.e_req));
      if (v.e_req) begin
         chk({nm, ".req_id"},  64'(bus_req_id_o),      64'(v.e_id));
         chk({nm, ".req_msg"}, 64'(bus_req_message_o), 64'(v.e_msg));
      end
      chk({nm, ".fill_vld"}, 64'(fill_vld_o), 64'(v.e_fill));
      if (v.e_fill) begin
         chk({nm, ".fill_tag"},  64'(fill_tag_o),  64'(v.e_ftag));
         chk({nm, ".fill_idx"},  64'(fill_idx_o),  64'(v.e_fidx));
         chk({nm, ".fill_data"}, fill_data_o,      v.e_fdata);
         chk({nm, ".fill_dty"},  64'(fill_dty_o),  64'(v.e_dty));
      end
   endtask

   task automatic check_cleared(input string nm);
      chk({nm, ".ack"},      64'(alloc_ack_o),   64'd0);
      chk({nm, ".merge"},    64'(alloc_merge_o), 64'd0);
      chk({nm, ".full"},     64'(full_o),        64'd0);
      chk({nm, ".req_en"},   64'(bus_req_en_o),  64'd0);
      chk({nm, ".fill_vld"}, 64'(fill_vld_o),    64'd0);
      chk({nm, ".fill_dty"}, 64'(fill_dty_o),    64'd0);
`ifdef DCACHE_MSHR_STATS_EN
      chk({nm, ".stat_miss"},  64'(stat_miss_cnt_o),  64'd0);
      chk({nm, ".stat_merge"}, 64'(stat_merge_cnt_o), 64'd0);
      chk({nm, ".stat_full"},  64'(stat_full_cyc_o),  64'd0);
`endif
   endtask

   task automatic do_reset(input string nm);
      @(negedge clk);
      idle();
      rst = 1'b1;
      #1;
      check_cleared(nm);
      @(negedge clk);
      rst = 1'b0;
   endtask

   vec_t tv [$];
   vec_t sq [$];

   initial begin
      rst = 1'b1;
      idle();

      // Basic load, store merge, refused store on GET_S, FILL retry, ack-wins race.
      tv.push_back(mk(1,0,'h12,3,0,      0,0,0,0,0,       1,0,0, 0,0,GET_S, 0,0,0,0,0));
      tv.push_back(mk(0,0,0,0,0,         1,0,0,0,0,       0,0,0, 1,0,GET_S, 0,0,0,0,0));
      tv.push_back(mk(0,0,0,0,0,         0,1,0,'hAA,0,    0,0,0, 0,0,GET_S, 0,0,0,0,0));
      tv.push_back(mk(0,0,0,0,0,         0,0,0,0,1,       0,0,0, 0,0,GET_S, 1,'h12,3,'hAA,0));
      tv.push_back(mk(0,0,0,0,0,         0,0,0,0,0,       0,0,0, 0,0,GET_S, 0,0,0,0,0));
      tv.push_back(mk(1,0,'h20,1,0,      0,0,0,0,0,       1,0,0, 0,0,GET_S, 0,0,0,0,0));
      tv.push_back(mk(1,1,'h20,1,'h5555, 0,0,0,0,0,       1,1,0, 1,0,GET_S, 0,0,0,0,0));
      tv.push_back(mk(0,0,0,0,0,         1,0,0,0,0,       0,0,0, 1,0,GET_M, 0,0,0,0,0));
      tv.push_back(mk(0,0,0,0,0,         0,1,0,'hBB,0,    0,0,0, 0,0,GET_S, 0,0,0,0,0));
      tv.push_back(mk(0,0,0,0,0,         0,0,0,0,1,       0,0,0, 0,0,GET_S, 1,'h20,1,'h5555,1));
      tv.push_back(mk(0,0,0,0,0,         0,0,0,0,0,       0,0,0, 0,0,GET_S, 0,0,0,0,0));
      tv.push_back(mk(1,0,'h30,2,0,      0,0,0,0,0,       1,0,0, 0,0,GET_S, 0,0,0,0,0));
      tv.push_back(mk(0,0,0,0,0,         1,0,0,0,0,       0,0,0, 1,0,GET_S, 0,0,0,0,0));
      tv.push_back(mk(1,1,'h30,2,'h77,   0,0,0,0,0,       0,0,0, 0,0,GET_S, 0,0,0,0,0));
      tv.push_back(mk(1,0,'h30,2,0,      0,0,0,0,0,       1,1,0, 0,0,GET_S, 0,0,0,0,0));
      tv.push_back(mk(0,0,0,0,0,         0,1,0,'hCC,0,    0,0,0, 0,0,GET_S, 0,0,0,0,0));
      tv.push_back(mk(1,0,'h30,2,0,      0,0,0,0,1,       0,0,0, 0,0,GET_S, 1,'h30,2,'hCC,0));
      tv.push_back(mk(1,0,'h30,2,0,      0,0,0,0,0,       1,0,0, 0,0,GET_S, 0,0,0,0,0));
      tv.push_back(mk(0,0,0,0,0,         1,0,0,0,0,       0,0,0, 1,0,GET_S, 0,0,0,0,0));
      tv.push_back(mk(0,0,0,0,0,         0,1,0,'h11,0,    0,0,0, 0,0,GET_S, 0,0,0,0,0));
      tv.push_back(mk(0,0,0,0,0,         0,0,0,0,1,       0,0,0, 0,0,GET_S, 1,'h30,2,'h11,0));
      tv.push_back(mk(0,0,0,0,0,         0,0,0,0,0,       0,0,0, 0,0,GET_S, 0,0,0,0,0));
      tv.push_back(mk(1,0,'h40,0,0,      0,0,0,0,0,       1,0,0, 0,0,GET_S, 0,0,0,0,0));
      tv.push_back(mk(1,1,'h40,0,'h77,   1,0,0,0,0,       0,0,0, 1,0,GET_S, 0,0,0,0,0));
      tv.push_back(mk(0,0,0,0,0,         0,1,0,'h99,0,    0,0,0, 0,0,GET_S, 0,0,0,0,0));
      tv.push_back(mk(0,0,0,0,0,         0,0,0,0,1,       0,0,0, 0,0,GET_S, 1,'h40,0,'h99,0));
      tv.push_back(mk(0,0,0,0,0,         0,0,0,0,0,       0,0,0, 0,0,GET_S, 0,0,0,0,0));

      do_reset("reset0");
      foreach (tv[i]) apply(tv[i], $sformatf("tbl[%0d]", i));

      // Fill all four entries, refuse the fifth, free one, retry.
      do_reset("reset1");
      sq.push_back(mk(1,0,1,0,0,         0,0,0,0,0,       1,0,0, 0,0,GET_S, 0,0,0,0,0));
      sq.push_back(mk(1,0,2,0,0,         0,0,0,0,0,       1,0,0, 1,0,GET_S, 0,0,0,0,0));
      sq.push_back(mk(1,0,3,0,0,         0,0,0,0,0,       1,0,0, 1,0,GET_S, 0,0,0,0,0));
      sq.push_back(mk(1,0,4,0,0,         0,0,0,0,0,       1,0,0, 1,0,GET_S, 0,0,0,0,0));
      sq.push_back(mk(1,0,5,0,0,         1,0,0,0,0,       0,0,1, 1,0,GET_S, 0,0,0,0,0));
      sq.push_back(mk(0,0,0,0,0,         0,1,0,'hD0,0,    0,0,1, 1,1,GET_S, 0,0,0,0,0));
      sq.push_back(mk(1,0,5,0,0,         0,0,0,0,1,       0,0,1, 1,1,GET_S, 1,1,0,'hD0,0));
      sq.push_back(mk(1,0,5,0,0,         0,0,0,0,0,       1,0,0, 1,1,GET_S, 0,0,0,0,0));
      sq.push_back(mk(0,0,0,0,0,         0,0,0,0,0,       0,0,1, 1,1,GET_S, 0,0,0,0,0));
      foreach (sq[i]) apply(sq[i], $sformatf("full[%0d]", i));

      // Responses 2,0,1 out of order; fills come out lowest FILL index first.
      do_reset("reset2");
      sq.delete();
      sq.push_back(mk(1,0,'hA0,1,0,      0,0,0,0,0,       1,0,0, 0,0,GET_S, 0,0,0,0,0));
      sq.push_back(mk(1,0,'hA1,1,0,      1,0,0,0,0,       1,0,0, 1,0,GET_S, 0,0,0,0,0));
      sq.push_back(mk(1,0,'hA2,1,0,      1,0,0,0,0,       1,0,0, 1,1,GET_S, 0,0,0,0,0));
      sq.push_back(mk(0,0,0,0,0,         1,0,0,0,0,       0,0,0, 1,2,GET_S, 0,0,0,0,0));
      sq.push_back(mk(0,0,0,0,0,         0,1,2,'h22,0,    0,0,0, 0,0,GET_S, 0,0,0,0,0));
      sq.push_back(mk(0,0,0,0,0,         0,1,0,'h20,0,    0,0,0, 0,0,GET_S, 1,'hA2,1,'h22,0));
      sq.push_back(mk(0,0,0,0,0,         0,1,1,'h21,1,    0,0,0, 0,0,GET_S, 1,'hA0,1,'h20,0));
      sq.push_back(mk(0,0,0,0,0,         0,0,0,0,1,       0,0,0, 0,0,GET_S, 1,'hA1,1,'h21,0));
      sq.push_back(mk(0,0,0,0,0,         0,0,0,0,1,       0,0,0, 0,0,GET_S, 1,'hA2,1,'h22,0));
      sq.push_back(mk(0,0,0,0,0,         0,0,0,0,0,       0,0,0, 0,0,GET_S, 0,0,0,0,0));
      foreach (sq[i]) apply(sq[i], $sformatf("ooo[%0d]", i));

      // Reset with two ISSUED entries; late responses must be ignored.
      do_reset("reset3");
      sq.delete();
      sq.push_back(mk(1,0,'hB0,0,0,      0,0,0,0,0,       1,0,0, 0,0,GET_S, 0,0,0,0,0));
      sq.push_back(mk(1,0,'hB1,0,0,      1,0,0,0,0,       1,0,0, 1,0,GET_S, 0,0,0,0,0));
      sq.push_back(mk(0,0,0,0,0,         1,0,0,0,0,       0,0,0, 1,1,GET_S, 0,0,0,0,0));
      sq.push_back(mk(0,0,0,0,0,         0,0,0,0,0,       0,0,0, 0,0,GET_S, 0,0,0,0,0));
      foreach (sq[i]) apply(sq[i], $sformatf("rst_pre[%0d]", i));
      #2;
      rst = 1'b1;
      #1;
      check_cleared("rst_mid");
      @(negedge clk);
      rst = 1'b0;
      sq.delete();
      sq.push_back(mk(0,0,0,0,0,         0,1,1,'h55,0,    0,0,0, 0,0,GET_S, 0,0,0,0,0));
      sq.push_back(mk(1,0,'hB1,0,0,      0,1,0,'h56,0,    1,0,0, 0,0,GET_S, 0,0,0,0,0));
      sq.push_back(mk(0,0,0,0,0,         0,0,0,0,0,       0,0,0, 1,0,GET_S, 0,0,0,0,0));
      foreach (sq[i]) apply(sq[i], $sformatf("rst_post[%0d]", i));

      @(negedge clk);
      idle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
